// File: rtl/risc_pkg.sv
// Shared definitions for the risc16-family fetch front end: the instruction
// that decode sees when nothing is queued, the default PC increment and the queue entry layout.
package risc_pkg;

  localparam int XLEN_DEFAULT    = 16;
  localparam int PC_STEP_DEFAULT = 2;

  localparam logic [XLEN_DEFAULT-1:0] NOP_INSN = '0;

  // One prefetched instruction together with the address it was fetched from
  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [XLEN_DEFAULT-1:0] ir;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Generic DEPTH x WIDTH synchronous FIFO with flush; flush overrides push/pop.
// The head entry is presented combinationally on head_data.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // Overflowing pushes and underflowing pops are dropped so the pointers stay consistent
  assign push_ok = push && !flush && (count != CW'(DEPTH));
  assign pop_ok  = pop  && !flush && (count != '0);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !rst) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/risc_fetch_unit.sv
// Instruction fetch front end: PC sequencer, memory request logic and a
// prefetch queue of {pc, instruction} pairs feeding decode.
module risc_fetch_unit
  import risc_pkg::*;
#(
  parameter int              XLEN     = 16,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [XLEN-1:0]        i_addr,
  output logic                   i_oe,
  input  logic                   i_ready,
  input  logic [XLEN-1:0]        i_din,
  input  logic                   redirect,
  input  logic [XLEN-1:0]        redirect_pc,
  output logic                   id_valid,
  input  logic                   id_ready,
  output logic [XLEN-1:0]        id_ir,
  output logic [XLEN-1:0]        id_pc,
  output logic [$clog2(DEPTH):0] q_count
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0]   fetch_pc;
  logic [CW-1:0]     count;
  logic [2*XLEN-1:0] head;
  logic              full;
  logic              push;
  logic              pop;

  // Requests look only at the registered occupancy, so a full queue waits a cycle after a pop
  assign full     = (count == CW'(DEPTH));
  assign i_oe     = !rst && !full && !redirect;
  assign push     = i_oe && i_ready;
  assign id_valid = !rst && (count != '0);
  assign pop      = id_valid && id_ready && !redirect;

  always_ff @(posedge clk) begin
    if (rst)           fetch_pc <= RESET_PC;
    else if (redirect) fetch_pc <= redirect_pc;
    else if (push)     fetch_pc <= fetch_pc + XLEN'(PC_STEP);
  end

  fetch_queue #(
    .DEPTH (DEPTH),
    .WIDTH (2*XLEN)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (push),
    .push_data ({fetch_pc, i_din}),
    .pop       (pop),
    .head_data (head),
    .count     (count)
  );

  assign i_addr  = fetch_pc;
  assign q_count = rst ? '0 : count;
  assign id_pc   = id_valid ? head[2*XLEN-1:XLEN] : '0;
  assign id_ir   = id_valid ? head[XLEN-1:0]      : XLEN'(NOP_INSN);

endmodule

// File: tb/tb_risc_fetch_unit.sv
// Self-checking bench for risc_fetch_unit: directed scenarios plus a randomized
// run compared against a queue-based model of the fetch front end.
module tb_risc_fetch_unit;

  localparam int XLEN  = 16;
  localparam int DEPTH = 4;

  logic            clk;
  logic            rst;
  logic [XLEN-1:0] i_addr;
  logic            i_oe;
  logic            i_ready;
  logic [XLEN-1:0] i_din;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            id_valid;
  logic            id_ready;
  logic [XLEN-1:0] id_ir;
  logic [XLEN-1:0] id_pc;
  logic [2:0]      q_count;

  int checks = 0;
  int errors = 0;

  // Reference model: fetch address plus a queue of fetched {pc, ir} pairs
  logic [XLEN-1:0] m_pc = '0;
  logic [XLEN-1:0] mq_pc[$];
  logic [XLEN-1:0] mq_ir[$];

  risc_fetch_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(16'h0000), .PC_STEP(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_addr      (i_addr),
    .i_oe        (i_oe),
    .i_ready     (i_ready),
    .i_din       (i_din),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_ir       (id_ir),
    .id_pc       (id_pc),
    .q_count     (q_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs away from the rising edge and let outputs settle
  task automatic applyStimulus(input logic r, input logic ir_rdy, input logic id_rdy,
                               input logic red, input logic [XLEN-1:0] rpc,
                               input logic [XLEN-1:0] din);
    rst = r; i_ready = ir_rdy; id_ready = id_rdy; redirect = red;
    redirect_pc = rpc; i_din = din;
    #1;
  endtask

  // Take one rising edge and move the model forward by the same rules
  task automatic advanceClock();
    bit do_push, do_pop;
    do_push = !rst && !redirect && (mq_pc.size() < DEPTH) && i_ready;
    do_pop  = !rst && !redirect && (mq_pc.size() > 0) && id_ready;
    @(posedge clk);
    if (rst) begin
      mq_pc.delete(); mq_ir.delete(); m_pc = 16'h0000;
    end else if (redirect) begin
      mq_pc.delete(); mq_ir.delete(); m_pc = redirect_pc;
    end else begin
      if (do_pop) begin void'(mq_pc.pop_front()); void'(mq_ir.pop_front()); end
      if (do_push) begin mq_pc.push_back(m_pc); mq_ir.push_back(i_din); m_pc = m_pc + 16'd2; end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    applyStimulus(1, 1, 1, 0, 0, 16'h1234);
    checks++; if (i_oe !== 1'b0) begin errors++; $display("[TB] FAIL reset_i_oe: got %b expected 0", i_oe); end
    checks++; if (id_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_id_valid: got %b expected 0", id_valid); end
    checks++; if (id_ir !== 16'h0) begin errors++; $display("[TB] FAIL reset_id_ir: got %h expected 0000", id_ir); end
    checks++; if (id_pc !== 16'h0) begin errors++; $display("[TB] FAIL reset_id_pc: got %h expected 0000", id_pc); end
    checks++; if (q_count !== 3'd0) begin errors++; $display("[TB] FAIL reset_q_count: got %0d expected 0", q_count); end
    advanceClock();
    applyStimulus(1, 1, 1, 0, 0, 16'h1234);
    advanceClock();
    applyStimulus(0, 1, 1, 0, 0, 16'h1234);
    checks++; if (i_addr !== 16'h0) begin errors++; $display("[TB] FAIL reset_i_addr: got %h expected 0000", i_addr); end
    checks++; if (q_count !== 3'd0) begin errors++; $display("[TB] FAIL reset_release_count: got %0d expected 0", q_count); end
    checks++; if (i_oe !== 1'b1) begin errors++; $display("[TB] FAIL reset_release_i_oe: got %b expected 1", i_oe); end
  endtask

  task automatic test_stream();
    for (int k = 0; k < 6; k++) begin
      applyStimulus(0, 1, 1, 0, 0, 16'($urandom));
      checks++; if (i_addr !== 16'(2*k)) begin errors++; $display("[TB] FAIL stream_i_addr[%0d]: got %h expected %h", k, i_addr, 16'(2*k)); end
      checks++; if (q_count !== ((k == 0) ? 3'd0 : 3'd1)) begin errors++; $display("[TB] FAIL stream_q_count[%0d]: got %0d expected %0d", k, q_count, (k == 0) ? 0 : 1); end
      checks++; if (id_valid !== (k > 0)) begin errors++; $display("[TB] FAIL stream_id_valid[%0d]: got %b expected %b", k, id_valid, k > 0); end
      if (k > 0) begin
        checks++; if (id_pc !== 16'(2*(k-1))) begin errors++; $display("[TB] FAIL stream_id_pc[%0d]: got %h expected %h", k, id_pc, 16'(2*(k-1))); end
        checks++; if (id_ir !== mq_ir[0]) begin errors++; $display("[TB] FAIL stream_id_ir[%0d]: got %h expected %h", k, id_ir, mq_ir[0]); end
      end
      advanceClock();
    end
  endtask

  task automatic test_backpressure();
    applyStimulus(1, 1, 1, 0, 0, 0);
    advanceClock();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 1, 0, 0, 0, 16'($urandom));
      checks++; if (i_addr !== 16'(2*k)) begin errors++; $display("[TB] FAIL bp_i_addr[%0d]: got %h expected %h", k, i_addr, 16'(2*k)); end
      advanceClock();
    end
    applyStimulus(0, 1, 0, 0, 0, 16'($urandom));
    checks++; if (q_count !== 3'd4) begin errors++; $display("[TB] FAIL bp_full_count: got %0d expected 4", q_count); end
    checks++; if (i_oe !== 1'b0) begin errors++; $display("[TB] FAIL bp_full_i_oe: got %b expected 0", i_oe); end
    checks++; if (i_addr !== 16'h8) begin errors++; $display("[TB] FAIL bp_full_i_addr: got %h expected 0008", i_addr); end
    advanceClock();
    applyStimulus(0, 1, 1, 0, 0, 16'($urandom));
    checks++; if (i_oe !== 1'b0) begin errors++; $display("[TB] FAIL bp_no_bypass_i_oe: got %b expected 0", i_oe); end
    checks++; if (id_pc !== 16'h0) begin errors++; $display("[TB] FAIL bp_head_pc: got %h expected 0000", id_pc); end
    advanceClock();
    applyStimulus(0, 1, 0, 0, 0, 16'($urandom));
    checks++; if (q_count !== 3'd3) begin errors++; $display("[TB] FAIL bp_after_pop_count: got %0d expected 3", q_count); end
    checks++; if (i_oe !== 1'b1) begin errors++; $display("[TB] FAIL bp_after_pop_i_oe: got %b expected 1", i_oe); end
    checks++; if (id_pc !== 16'h2) begin errors++; $display("[TB] FAIL bp_after_pop_pc: got %h expected 0002", id_pc); end
    advanceClock();
  endtask

  task automatic test_wait_states();
    applyStimulus(1, 1, 1, 0, 0, 0);
    advanceClock();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 1, 0, 0, 0, 16'($urandom));
      advanceClock();
    end
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 0, 0, 0, 0, 16'($urandom));
      checks++; if (i_addr !== 16'h6 || i_oe !== 1'b1) begin errors++; $display("[TB] FAIL wait_hold[%0d]: got addr %h oe %b expected 0006 1", k, i_addr, i_oe); end
      advanceClock();
    end
    applyStimulus(0, 1, 0, 0, 0, 16'hBEEF);
    checks++; if (q_count !== 3'd3) begin errors++; $display("[TB] FAIL wait_no_push_count: got %0d expected 3", q_count); end
    advanceClock();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 0, 1, 0, 0, 0);
      advanceClock();
    end
    applyStimulus(0, 0, 0, 0, 0, 0);
    checks++; if (id_pc !== 16'h6) begin errors++; $display("[TB] FAIL wait_accept_pc: got %h expected 0006", id_pc); end
    checks++; if (id_ir !== 16'hBEEF) begin errors++; $display("[TB] FAIL wait_accept_ir: got %h expected beef", id_ir); end
  endtask

  task automatic test_redirect();
    applyStimulus(1, 1, 1, 0, 0, 0);
    advanceClock();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 1, 0, 0, 0, 16'($urandom));
      advanceClock();
    end
    applyStimulus(0, 1, 1, 1, 16'h0040, 16'($urandom));
    checks++; if (i_oe !== 1'b0) begin errors++; $display("[TB] FAIL redir_i_oe: got %b expected 0", i_oe); end
    checks++; if (q_count !== 3'd3) begin errors++; $display("[TB] FAIL redir_pre_count: got %0d expected 3", q_count); end
    advanceClock();
    applyStimulus(0, 1, 1, 0, 0, 16'($urandom));
    checks++; if (q_count !== 3'd0 || id_valid !== 1'b0 || id_ir !== 16'h0) begin errors++; $display("[TB] FAIL redir_flush: got count %0d valid %b ir %h expected 0 0 0000", q_count, id_valid, id_ir); end
    checks++; if (i_addr !== 16'h0040 || i_oe !== 1'b1) begin errors++; $display("[TB] FAIL redir_target: got addr %h oe %b expected 0040 1", i_addr, i_oe); end
    advanceClock();
    applyStimulus(0, 1, 1, 0, 0, 16'($urandom));
    checks++; if (id_valid !== 1'b1 || id_pc !== 16'h0040) begin errors++; $display("[TB] FAIL redir_first_insn: got valid %b pc %h expected 1 0040", id_valid, id_pc); end
    applyStimulus(0, 1, 1, 1, 16'h0100, 0);
    advanceClock();
    applyStimulus(0, 1, 1, 1, 16'h0200, 0);
    advanceClock();
    applyStimulus(0, 1, 1, 0, 0, 16'($urandom));
    checks++; if (i_addr !== 16'h0200 || q_count !== 3'd0) begin errors++; $display("[TB] FAIL redir_held: got addr %h count %0d expected 0200 0", i_addr, q_count); end
    advanceClock();
  endtask

  task automatic test_wrap();
    logic [XLEN-1:0] exp_addr [3];
    exp_addr = '{16'hFFFC, 16'hFFFE, 16'h0000};
    applyStimulus(0, 1, 1, 1, 16'hFFFC, 0);
    advanceClock();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 1, 1, 0, 0, 16'($urandom));
      checks++; if (i_addr !== exp_addr[k]) begin errors++; $display("[TB] FAIL wrap_i_addr[%0d]: got %h expected %h", k, i_addr, exp_addr[k]); end
      advanceClock();
    end
  endtask

  task automatic test_reset_mid();
    applyStimulus(1, 1, 1, 0, 0, 0);
    advanceClock();
    for (int k = 0; k < 2; k++) begin
      applyStimulus(0, 1, 0, 0, 0, 16'($urandom));
      advanceClock();
    end
    applyStimulus(0, 1, 0, 0, 0, 0);
    checks++; if (q_count !== 3'd2) begin errors++; $display("[TB] FAIL rstmid_pre_count: got %0d expected 2", q_count); end
    applyStimulus(1, 1, 0, 0, 0, 0);
    checks++; if (i_oe !== 1'b0 || id_valid !== 1'b0 || q_count !== 3'd0) begin errors++; $display("[TB] FAIL rstmid_during: got oe %b valid %b count %0d expected 0 0 0", i_oe, id_valid, q_count); end
    advanceClock();
    applyStimulus(0, 1, 0, 0, 0, 16'($urandom));
    checks++; if (q_count !== 3'd0 || i_addr !== 16'h0) begin errors++; $display("[TB] FAIL rstmid_after: got count %0d addr %h expected 0 0000", q_count, i_addr); end
    advanceClock();
    applyStimulus(1, 1, 1, 1, 16'h0080, 0);
    advanceClock();
    applyStimulus(0, 1, 1, 0, 0, 0);
    checks++; if (i_addr !== 16'h0 || q_count !== 3'd0) begin errors++; $display("[TB] FAIL rstmid_redirect: got addr %h count %0d expected 0000 0", i_addr, q_count); end
  endtask

  task automatic test_random();
    logic [52:0] got, exp;
    logic e_valid;
    applyStimulus(1, 1, 1, 0, 0, 0);
    advanceClock();
    for (int n = 0; n < 400; n++) begin
      applyStimulus(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 7),
                    ($urandom_range(0, 9) < 6), ($urandom_range(0, 11) == 0),
                    16'($urandom) & 16'hFFFE, 16'($urandom));
      e_valid = !rst && (mq_pc.size() > 0);
      exp = {!rst && (mq_pc.size() < DEPTH) && !redirect, e_valid,
             rst ? 3'd0 : 3'(mq_pc.size()), m_pc,
             e_valid ? mq_pc[0] : 16'h0, e_valid ? mq_ir[0] : 16'h0};
      got = {i_oe, id_valid, q_count, i_addr, id_pc, id_ir};
      checks++; if (got !== exp) begin errors++; $display("[TB] FAIL random[%0d] {oe,valid,count,addr,pc,ir}: got %h expected %h", n, got, exp); end
      advanceClock();
    end
  endtask

  initial begin
    rst = 1'b1; i_ready = 1'b0; id_ready = 1'b0; redirect = 1'b0;
    redirect_pc = '0; i_din = '0;
    $display("[TB] starting risc_fetch_unit bench");
    test_reset();
    test_stream();
    test_backpressure();
    test_wait_states();
    test_redirect();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
